// File: rtl/mult_32bit_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_32bit_seq_pkg
// Shared constants and types for the sequential shift-add multiplier and the
// 32-bit ALU it drives.
//   N            : operand width (fixed at 32 to match alu_32bit)
//   ALU_*        : ALU op codes understood by alu_32bit
//   ITER_COUNT   : shift-add iterations per multiply (one per multiplier bit)
//   state_t      : multiplier FSM encoding
// -----------------------------------------------------------------------------
package mult_32bit_seq_pkg;

    localparam int N = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b111;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = $clog2(ITER_COUNT);
    // Counter value seen on the final iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_32bit_seq_if.sv
// -----------------------------------------------------------------------------
// mult_32bit_seq_if
// Start/done handshake between the controller (master) and the multiply unit
// (slave).
//   start         controller -> unit  request, sampled only while idle
//   multiplicand  controller -> unit  operand M
//   multiplier    controller -> unit  operand Q
//   abort         controller -> unit  cancel a running multiply
//                                     (only when MULT_ABORT_EN is defined)
//   product       unit -> controller  64-bit result
//   busy          unit -> controller  unit not idle
//   done          unit -> controller  one-cycle pulse, product valid
// Optional feature macro: MULT_ABORT_EN
// -----------------------------------------------------------------------------
interface mult_32bit_seq_if;
    import mult_32bit_seq_pkg::*;

    logic           start;
    logic [N-1:0]   multiplicand;
    logic [N-1:0]   multiplier;
`ifdef MULT_ABORT_EN
    logic           abort;
`endif
    logic [2*N-1:0] product;
    logic           busy;
    logic           done;

    modport master (
        output start, multiplicand, multiplier,
`ifdef MULT_ABORT_EN
        output abort,
`endif
        input  product, busy, done
    );

    modport slave (
        input  start, multiplicand, multiplier,
`ifdef MULT_ABORT_EN
        input  abort,
`endif
        output product, busy, done
    );

endinterface

// File: rtl/alu_32bit.sv
// -----------------------------------------------------------------------------
// alu_32bit
// Combinational 32-bit ALU of the Hw4 datapath.
//   a, b   : operands
//   Aluop  : ALU_ADD (a+b+cin), ALU_SLT (signed a<b), ALU_OR (a|b)
//   cin    : carry in for ALU_ADD
//   R      : result
//   cout   : carry out of ALU_ADD
//   S      : sign of R
//   V      : signed overflow of ALU_ADD
// -----------------------------------------------------------------------------
module alu_32bit
    import mult_32bit_seq_pkg::*;
(
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   Aluop,
    input  logic         cin,
    output logic [N-1:0] R,
    output logic         cout,
    output logic         S,
    output logic         V
);

    logic [N:0] sum;

    assign sum = {1'b0, a} + {1'b0, b} + (N+1)'(cin);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        R    = '0;
        cout = 1'b0;
        V    = 1'b0;
        case (Aluop)
            ALU_ADD: begin
                {cout, R} = sum;
                V = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            ALU_SLT: R = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OR:  R = a | b;
            default: R = '0;
        endcase
        S = R[N-1];
    end

endmodule

// File: rtl/mult_32bit_seq.sv
// -----------------------------------------------------------------------------
// mult_32bit_seq
// Sequential 32x32 unsigned shift-add multiplier. Each CALC cycle the ALU adds
// the multiplicand to the accumulator (upper half of p_reg); the sum and its
// carry are kept or discarded depending on the current multiplier LSB, and the
// whole product register shifts right by one.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of mult_32bit_seq_if (start/operands in,
//              product/busy/done out, abort in with MULT_ABORT_EN)
// Optional feature macro: MULT_ABORT_EN (adds abort of a running multiply)
// -----------------------------------------------------------------------------
module mult_32bit_seq
    import mult_32bit_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    mult_32bit_seq_if.slave bus
);

    state_t           state, state_nxt;
    logic [N-1:0]     m_reg, m_nxt;
    logic [2*N-1:0]   p_reg, p_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [N-1:0]     alu_r;
    logic             alu_cout;
    logic             alu_s_unused;
    logic             alu_v_unused;

    // Accumulator plus multiplicand; only the add op is ever requested.
    alu_32bit u_alu (
        .a     (p_reg[2*N-1:N]),
        .b     (m_reg),
        .Aluop (ALU_ADD),
        .cin   (1'b0),
        .R     (alu_r),
        .cout  (alu_cout),
        .S     (alu_s_unused),
        .V     (alu_v_unused)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            m_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state <= state_nxt;
            m_reg <= m_nxt;
            p_reg <= p_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m_reg;
        p_nxt     = p_reg;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    m_nxt     = bus.multiplicand;
                    p_nxt     = {{N{1'b0}}, bus.multiplier};
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
`ifdef MULT_ABORT_EN
                // Abort takes priority, including over the final iteration.
                if (bus.abort) begin
                    p_nxt     = '0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else
`endif
                begin
                    // Carry out of the add becomes the new MSB after the shift.
                    if (p_reg[0]) p_nxt = {alu_cout, alu_r, p_reg[N-1:1]};
                    else          p_nxt = {1'b0, p_reg[2*N-1:1]};
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.product = p_reg;
    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_mult_32bit_seq.sv
// -----------------------------------------------------------------------------
// tb_mult_32bit_seq
// Directed vectors for mult_32bit_seq. Each accepted start pushes the expected
// product and the clock edge at which done must be seen; a monitor pops and
// compares whenever done is presented.
// Edge numbering: start accepted at E0, done visible between E32 and E33.
// -----------------------------------------------------------------------------
module tb_mult_32bit_seq;
    import mult_32bit_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mult_32bit_seq_if mif ();

    mult_32bit_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mif)
    );

    typedef struct {
        logic [63:0] product;
        int          done_edge;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at the negedge after the start edge E0; done must show after E32.
    task automatic push_exp(input string name, input logic [63:0] exp);
        sb.push_back('{product: exp, done_edge: cyc + 32, name: name});
    endtask

    task automatic issue(input string name, input logic [31:0] m, input logic [31:0] q,
                         input logic [63:0] exp);
        @(negedge clk);
        mif.start        = 1'b1;
        mif.multiplicand = m;
        mif.multiplier   = q;
        @(negedge clk);
        mif.start = 1'b0;
        push_exp(name, exp);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((sb.size() != 0 || mif.busy !== 1'b0) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL idle timeout: %0d results outstanding, busy=%b", sb.size(), mif.busy);
            sb.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && mif.done !== 1'b0) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected done: got done=%b product=%h at edge %0d, expected no done",
                         mif.done, mif.product, cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, " product"}, mif.product, e.product);
                check({e.name, " done edge"}, 64'(cyc), 64'(e.done_edge));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n          = 1'b0;
        mif.start        = 1'b0;
        mif.multiplicand = '0;
        mif.multiplier   = '0;
`ifdef MULT_ABORT_EN
        mif.abort        = 1'b0;
`endif
        #1;
        check("reset product", mif.product, 64'd0);
        check("reset busy", 64'(mif.busy), 64'd0);
        check("reset done", 64'(mif.done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Basic run with explicit busy timing around the result.
        issue("3x5", 32'd3, 32'd5, 64'd15);
        check("busy after start", 64'(mif.busy), 64'd1);
        repeat (33) @(negedge clk);
        check("busy after done", 64'(mif.busy), 64'd0);
        check("product held in idle", mif.product, 64'd15);
        wait_idle();

        issue("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        wait_idle();
        issue("2^16x2^16", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        wait_idle();
        issue("0xdeadbeef", 32'h0, 32'hDEAD_BEEF, 64'd0);
        wait_idle();

        // Start held high across two operations; operands change right after
        // E0, so the second pair is taken at the first idle edge (E34).
        @(negedge clk);
        mif.start        = 1'b1;
        mif.multiplicand = 32'd100;
        mif.multiplier   = 32'd200;
        @(negedge clk);
        push_exp("held first", 64'd20000);
        mif.multiplicand = 32'd12345;
        mif.multiplier   = 32'd1000;
        repeat (34) @(negedge clk);
        push_exp("held second", 64'd12345000);
        mif.start = 1'b0;
        // Start pulses with new operands during CALC must be ignored.
        repeat (3) begin
            @(negedge clk);
            mif.start        = 1'b1;
            mif.multiplicand = 32'd5;
            mif.multiplier   = 32'd5;
            @(negedge clk);
            mif.start = 1'b0;
        end
        wait_idle();

        // Reset in the middle of CALC: outputs clear at once, no done.
        @(negedge clk);
        mif.start        = 1'b1;
        mif.multiplicand = 32'd9;
        mif.multiplier   = 32'd9;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid reset product", mif.product, 64'd0);
        check("mid reset busy", 64'(mif.busy), 64'd0);
        check("mid reset done", 64'(mif.done), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("idle after mid reset", 64'(mif.busy), 64'd0);
        issue("7x6", 32'd7, 32'd6, 64'd42);
        wait_idle();

`ifdef MULT_ABORT_EN
        // Abort coinciding with the final iteration (cnt=31, between E31/E32).
        @(negedge clk);
        mif.start        = 1'b1;
        mif.multiplicand = 32'd11;
        mif.multiplier   = 32'd13;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (31) @(negedge clk);
        mif.abort = 1'b1;
        @(negedge clk);
        mif.abort = 1'b0;
        check("abort product", mif.product, 64'd0);
        check("abort busy", 64'(mif.busy), 64'd0);
        check("abort done", 64'(mif.done), 64'd0);
        repeat (3) @(negedge clk);
        issue("after abort", 32'd11, 32'd13, 64'd143);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
